// File: rtl/tx_arbiter_if.sv
// Bundle of the two requester handshakes, the UART transmitter hookup and the
// arbiter status lines. slave is the arbiter's view, master the environment's.
interface tx_arbiter_if;
  logic        req0_valid;
  logic [23:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        tx_busy;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        busy;
  logic        grant_id;
  logic        done;
  logic        timeout_err;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    output req0_ready, req1_ready, tx_send, tx_data, busy, grant_id, done, timeout_err
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    input  req0_ready, req1_ready, tx_send, tx_data, busy, grant_id, done, timeout_err
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding a byte-wide UART transmitter: req0 sends a 24-bit
// word MSB byte first, req1 a single byte; each byte is paced by tx_busy or a timeout.
module tx_arbiter #(
  parameter int unsigned MIN_GAP = 2,
  parameter int unsigned TIMEOUT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  tx_arbiter_if.slave bus
);
  localparam logic [15:0] L_MIN_GAP = 16'(MIN_GAP);
  localparam logic [15:0] L_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_shift;
  logic [1:0]  r_count;
  logic [15:0] r_timer;
  logic        r_last_grant;
  logic        r_grant_id;
  logic        r_done;
  logic        r_timeout_err;

  logic        w_take0;
  logic        w_take1;
  logic        w_gap_ok;
  logic        w_tmo;
  logic        w_byte_end;
  logic        w_last_byte;

  // Grant decision; r_last_grant = 1 means req0 wins the next tie
  always_comb begin
    w_take0 = 1'b0;
    w_take1 = 1'b0;
    if (reset_n && (r_state == ST_IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (r_last_grant) begin
          w_take0 = 1'b1;
        end else begin
          w_take1 = 1'b1;
        end
      end else if (bus.req0_valid) begin
        w_take0 = 1'b1;
      end else if (bus.req1_valid) begin
        w_take1 = 1'b1;
      end else begin
        w_take0 = 1'b0;
      end
    end else begin
      w_take1 = 1'b0;
    end
  end

  // Byte-end detection while waiting on the transmitter
  always_comb begin
    w_gap_ok = 1'b0;
    w_tmo    = 1'b0;
    if (r_state == ST_WAIT) begin
      w_gap_ok = (r_timer >= L_MIN_GAP) && !bus.tx_busy;
      w_tmo    = (r_timer >= L_TIMEOUT);
    end else begin
      w_tmo    = 1'b0;
    end
  end

  assign w_byte_end  = w_gap_ok | w_tmo;
  assign w_last_byte = (r_count == 2'd1);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take0 || w_take1) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!w_byte_end) begin
          w_state_nxt = ST_WAIT;
        end else if (w_last_byte) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_shift       <= 24'h000000;
      r_count       <= 2'd0;
      r_timer       <= 16'd0;
      r_last_grant  <= 1'b1;
      r_grant_id    <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= (w_state_nxt != r_state) ? 16'd0 : r_timer + 16'd1;
      r_done  <= w_byte_end && w_last_byte;
      if (w_tmo) begin
        r_timeout_err <= 1'b1;
      end
      if (w_take0) begin
        r_shift      <= bus.req0_data;
        r_count      <= 2'd3;
        r_grant_id   <= 1'b0;
        r_last_grant <= 1'b0;
      end else if (w_take1) begin
        r_shift      <= {bus.req1_data, 16'h0000};
        r_count      <= 2'd1;
        r_grant_id   <= 1'b1;
        r_last_grant <= 1'b1;
      end else if (w_byte_end) begin
        r_shift <= {r_shift[15:0], 8'h00};
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign bus.req0_ready  = w_take0;
  assign bus.req1_ready  = w_take1;
  assign bus.tx_send     = (r_state == ST_SEND);
  assign bus.tx_data     = (r_state == ST_IDLE) ? 8'h00 : r_shift[23:16];
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.grant_id    = r_grant_id;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter MIN_GAP, default 2: minimum clk cycles in WAIT before tx_busy low may end a byte.
REQ-002 SHALL have parameter TIMEOUT, default 868: clk cycles in WAIT after which a byte ends regardless of tx_busy.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req0_valid  input  1  measurement requester has a 24-bit word pending.
REQ-006 SHALL have port req0_data  input  24  measurement word, sent MSB byte first.
REQ-007 SHALL have port req0_ready  output  1  one-cycle accept of req0 (combinational, IDLE only).
REQ-008 SHALL have port req1_valid  input  1  reply requester has one byte pending.
REQ-009 SHALL have port req1_data  input  8  reply byte.
REQ-010 SHALL have port req1_ready  output  1  one-cycle accept of req1 (combinational, IDLE only).
REQ-011 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-012 SHALL have port tx_send  output  1  one-cycle start pulse to UART transmitter.
REQ-013 SHALL have port tx_data  output  8  byte to transmit, stable from tx_send until byte ends.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port grant_id  output  1  requester owning the current transfer (0/1).
REQ-016 SHALL have port done  output  1  one-cycle pulse when last byte of a transfer ends.
REQ-017 SHALL have port timeout_err  output  1  sticky flag, set when any byte ends by TIMEOUT.

Function
REQ-018 SHALL implement states IDLE, SEND, WAIT.
REQ-019 SHALL, in IDLE, grant req0 if only req0_valid, req1 if only req1_valid, and when both valid the requester not granted last (round-robin).
REQ-020 SHALL assert the granted reqX_ready in the same IDLE cycle, capture its data into a 24-bit shift register, set byte count (3 for req0, 1 for req1), update grant_id and last-grant, go to SEND.
REQ-021 SHALL left-align req1_data into shift register bits [23:16].
REQ-022 SHALL never assert req0_ready and req1_ready together, nor either outside IDLE.
REQ-023 SHALL require requesters to hold valid and data until ready; valid dropped before ready is a no-op.
REQ-024 SHALL, in SEND, assert tx_send for exactly one cycle with tx_data = shift[23:16], then go to WAIT.
REQ-025 SHALL run a 16-bit timer cleared on every state change, incrementing otherwise.
REQ-026 SHALL leave WAIT when (timer >= MIN_GAP and tx_busy = 0) or timer >= TIMEOUT; the latter sets timeout_err.
REQ-027 SHALL, on leaving WAIT, shift left by 8, decrement byte count; go to SEND if count > 0, else pulse done and go to IDLE.
REQ-028 SHALL hold tx_data constant through WAIT; tx_data = 0 in IDLE.
REQ-029 SHALL give latency: accept cycle N -> tx_send at cycle N+1; consecutive tx_send pulses >= MIN_GAP+2 cycles apart.
REQ-030 SHALL ignore tx_busy in IDLE and SEND; a new request during a transfer waits until IDLE.
REQ-031 SHALL allow a new accept in the IDLE cycle directly following done.

Reset
REQ-032 SHALL, on reset_n = 0 at a clock edge, enter IDLE; tx_send, done, busy, grant_id, timeout_err, tx_data, byte count, timer = 0; last-grant = 1 (req0 wins first tie).
REQ-033 SHALL abort any transfer mid-operation on reset: remaining bytes discarded, no done, no ready during reset.

Verification
REQ-034 SHALL cover: req0 0xA1B2C3, tx_busy high 10 cycles after each tx_send -> tx_data 0xA1, 0xB2, 0xC3 in order, 3 tx_send pulses, one done, timeout_err = 0.
REQ-035 SHALL cover: req0 and req1 (0x5A) valid in same cycle after reset -> req0 granted first; both again valid -> req1 granted next (alternation).
REQ-036 SHALL cover: tx_busy held 0 always -> each byte ends at timer = MIN_GAP, tx_send pulses 4 cycles apart.
REQ-037 SHALL cover: tx_busy stuck 1 -> each byte ends at timer = TIMEOUT, timeout_err = 1 and remains until reset.
REQ-038 SHALL cover: reset_n low during second byte of req0 -> next cycle IDLE, tx_send = 0, no third byte, no done; pending req1 accepted after release.
